mosfet_calc_stream: RTL
=======================

Name: mosfet_calc_stream

Overview:
Parametrised, sequential successor to the six-device MOSFET calculator. Device tuples (W, V_GS, V_DS) arrive serially, one per in_valid beat. Per device, the block computes drain current or transconductance and keeps a running top-K / bottom-K selection. After the last device it emits one weighted-average result with a valid pulse. It sits behind the lab pattern driver as a streaming replacement for the combinational calculator.

Parameters:
N_DEV, 6, devices per packet; must satisfy N_DEV >= K.
K, 3, number of devices selected for the output; must satisfy K >= 1.
VW, 3, bit width of W, V_GS and V_DS (unsigned).
OUT_W, 8, width of out_n; must satisfy OUT_W >= VAL_W.
VAL_W (localparam), bits needed for floor((2^VW-1)*(2^VW-2)^2/3); equals 7 at defaults.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  device beat valid.
mode  in  2  sampled on first beat only; mode[0]=1 selects current, 0 selects gm; mode[1]=1 selects largest K, 0 selects smallest K.
in_w  in  VW  device width.
in_vgs  in  VW  gate-source voltage.
in_vds  in  VW  drain-source voltage.
out_valid  out  1  result valid, one-cycle pulse.
out_n  out  OUT_W  result, zero-extended.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, beat count=0, selection registers cleared, out_valid=0, out_n=0. Reset mid-packet aborts the packet; no out_valid follows.
- out_n is 0 whenever out_valid=0.
- Per-device math, V_TH=1, all integer, each /3 floored per device:
  - V_GS<=1: cutoff, I=0, gm=0.
  - ov=V_GS-1.
  - Triode (ov > V_DS): I=W*(2*ov*V_DS - V_DS^2)/3, gm=2*W*V_DS/3.
  - Saturation (ov <= V_DS): I=W*ov^2/3, gm=2*W*ov/3.
- Only the quantity chosen by mode[0] is tracked; it is VAL_W bits wide.
- FSM:
  - IDLE: on in_valid, capture mode, insert beat 0, count=1, go to COLLECT. (If N_DEV==1, go straight to CALC.)
  - COLLECT: each in_valid beat inserts one value and increments count. in_valid=0 pauses the packet; gaps of any length are legal. When count reaches N_DEV, go to CALC.
  - CALC: one cycle; register the weighted sum.
  - OUT: out_valid=1 for one cycle, out_n=result, then IDLE.
  - in_valid in CALC or OUT is ignored; the data is dropped.
- Selection:
  - Keep a K-entry list sorted descending, holding the K largest (mode[1]=1) or K smallest (mode[1]=0) values.
  - Insertion is a parallel compare-shift, one value per cycle. Ties are resolved by value only; this does not affect the result.
- Output arithmetic, with selected values ranked r=0..K-1 in descending order:
  - Current mode: out = floor(sum((K+r)*v_r) / (K*(3K-1)/2)). At K=3 the weights are 3,4,5 and the divisor is 12.
  - gm mode: out = floor(sum(v_r) / K).
- Latency: out_valid rises exactly 2 rising edges after the edge that samples the last beat.
- Back-to-back: the next packet may start in the cycle immediately after out_valid. The in_valid sampled in OUT is ignored, so the first beat must come in the IDLE cycle or later.

Test Plan:
Reference packet D (W,VGS,VDS): (7,7,7)(7,7,1)(1,2,1)(3,4,2)(6,5,7)(0,7,7). Currents are 84,25,0,8,32,0; gm values are 28,4,0,4,16,0.
- Defaults, D, contiguous beats, four packets with mode=3,1,2,0 -> out_n=42, 2, 16, 1 respectively; out_valid high for exactly 1 cycle each; out_n=0 at all other times.
- D with mode=3 and in_valid low for 2 cycles between beats 2 and 3 -> out_n=42, out_valid exactly 2 edges after the final beat.
- Cutoff packet: all devices (7,1,7) or (7,0,3), mode=3 -> out_n=0.
- rst_n pulsed low asynchronously after 3 beats of D, then full D with mode=3 -> no out_valid from the aborted packet; a single out_n=42.
- Back-to-back: D mode=3, then D mode=2 starting in the cycle after out_valid -> 42 then 16; in_valid asserted during CALC is ignored.
- N_DEV=4, K=2, devices (7,7,7)(7,7,1)(3,4,2)(6,5,7), mode=3 -> out_n=floor((2*84+3*32)/5)=52.

Source files
------------

// File: rtl/mosfet_calc_stream.sv
// mosfet_calc_stream: serial MOSFET current/gm calculator with running top-K/bottom-K selection and weighted-average output
module mosfet_calc_stream #(
  parameter int N_DEV = 6,
  parameter int K = 3,
  parameter int VW = 3,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [VW-1:0]    in_w,
  input  logic [VW-1:0]    in_vgs,
  input  logic [VW-1:0]    in_vds,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_n
);
  localparam int MAXV = ((2**VW - 1) * (2**VW - 2)**2) / 3;
  localparam int VAL_W = $clog2(MAXV + 1);
  localparam int PW = 3 * VW + 2;
  localparam int SW = VAL_W + $clog2(2 * K * K + 1);
  localparam int CW = $clog2(N_DEV + 1);
  localparam int DIV = K * (3 * K - 1) / 2;
  localparam logic [PW-1:0] TWO = 2;
  localparam logic [PW-1:0] THREE = 3;
  typedef enum logic [1:0] {IDLE, COLLECT, CALC, OUT} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [1:0] mode_q, md;
  logic [K-1:0][VAL_W-1:0] sel, base, nxt;
  logic [PW-1:0] w, ov, vd, cur, gm;
  logic [VAL_W-1:0] v, res, res_d;
  logic [SW-1:0] sum;
  logic cut, triode, ins;
  // mode is live on the first beat, held for the rest of the packet
  assign md = (state == IDLE) ? mode : mode_q;
  assign ins = in_valid && (state == IDLE || state == COLLECT);
  always_comb begin
    w = PW'(in_w);
    vd = PW'(in_vds);
    ov = PW'(in_vgs) - PW'(1);
    cut = in_vgs <= VW'(1);
    triode = ov > vd;
    cur = triode ? w * (TWO * ov * vd - vd * vd) / THREE : w * ov * ov / THREE;
    gm = TWO * w * (triode ? vd : ov) / THREE;
    v = cut ? '0 : VAL_W'(md[0] ? cur : gm);
  end
  // list is kept descending; a new packet starts from all-zeros (top-K) or all-ones (bottom-K)
  always_comb begin
    base = (state == IDLE) ? {(K * VAL_W){~md[1]}} : sel;
    nxt = base;
    if (md[1]) begin
      nxt[0] = (v > base[0]) ? v : base[0];
      for (int i = 1; i < K; i++)
        nxt[i] = (v > base[i-1]) ? base[i-1] : (v > base[i]) ? v : base[i];
    end else begin
      nxt[K-1] = (v < base[K-1]) ? v : base[K-1];
      for (int i = 0; i < K - 1; i++)
        nxt[i] = (v < base[i+1]) ? base[i+1] : (v < base[i]) ? v : base[i];
    end
  end
  always_comb begin
    sum = '0;
    for (int r = 0; r < K; r++)
      sum += md[0] ? SW'(K + r) * SW'(sel[r]) : SW'(sel[r]);
    res_d = VAL_W'(sum / (md[0] ? SW'(DIV) : SW'(K)));
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid) state_d = (N_DEV == 1) ? CALC : COLLECT;
      COLLECT: if (in_valid && cnt == CW'(N_DEV - 1)) state_d = CALC;
      CALC:    state_d = OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mode_q <= '0;
      sel <= '0;
      res <= '0;
      out_valid <= 1'b0;
      out_n <= '0;
    end else begin
      state <= state_d;
      out_valid <= state == OUT;
      out_n <= (state == OUT) ? OUT_W'(res) : '0;
      if (state == CALC) res <= res_d;
      if (ins) begin
        sel <= nxt;
        cnt <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
      end
      if (state == IDLE && in_valid) mode_q <= mode;
    end
  end
endmodule
